// File: rtl/efuse_seq_ctrl.sv
// rtl/efuse_seq_ctrl.sv - eFuse macro port sequencer (shadow load and bitwise program)
//
// Purpose:
//   Drives the eFuse mux with registered pgmen/rden/aen/addr strobes.
//   Load reads NR/8 bytes into shadow_data. Program burns every set bit
//   of an NW-bit word, one bit per strobe.
//   Optional feature macro: EFUSE_SEQ_VERIFY_EN. When it is defined, a full
//   read pass follows programming, the captured bytes are compared with
//   wr_data and pgm_err is raised on any unburned bit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_read        1-cycle request to load the shadow register
//   start_write       1-cycle request to program wr_data
//   wr_data[NW]       bits to burn, sampled when start_write is accepted
//   done              1-cycle pulse at the end of any operation
//   shadow_data[NR]   loaded fuse contents, byte k at [8k+:8]
//   pgm_err           read-back mismatch flag (verify feature only)
//   busy_read         load in progress
//   busy_write        program (and verify) in progress
//   efuse_pgmen       program enable to the mux
//   efuse_rden        read enable to the mux
//   efuse_aen         access strobe to the mux
//   efuse_addr[8]     bit index (program) or byte index (read)
//   read_rdata[8]     read data returned from the mux

module efuse_seq_ctrl #(
    parameter int NW    = 64,
    parameter int NR    = 64,
    parameter int T_SU  = 2,
    parameter int T_RD  = 4,
    parameter int T_PGM = 100,
    parameter int T_HD  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_read,
    input  logic          start_write,
    input  logic [NW-1:0] wr_data,
    output logic          done,
    output logic [NR-1:0] shadow_data,
    output logic          pgm_err,
    output logic          busy_read,
    output logic          busy_write,
    output logic          efuse_pgmen,
    output logic          efuse_rden,
    output logic          efuse_aen,
    output logic [7:0]    efuse_addr,
    input  logic [7:0]    read_rdata
);

    localparam int NB    = NR / 8;
    localparam int T_AB  = (T_SU > T_RD) ? T_SU : T_RD;
    localparam int T_CD  = (T_PGM > T_HD) ? T_PGM : T_HD;
    localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] C_SU  = CW'(T_SU - 1);
    localparam logic [CW-1:0] C_RD  = CW'(T_RD - 1);
    localparam logic [CW-1:0] C_PGM = CW'(T_PGM - 1);
    localparam logic [CW-1:0] C_HD  = CW'(T_HD - 1);

    localparam logic [7:0] LAST_RD = 8'(NB - 1);
    localparam logic [7:0] LAST_WR = 8'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_idx;
    logic            r_rd_seq;     // current strobe sequence is a read (load or verify)
    logic [NW-1:0]   r_wr;
    logic            r_busy_rd;
    logic            r_busy_wr;
    logic            r_pgmen;
    logic            r_rden;
    logic            r_aen;
    logic [7:0]      r_addr;
    logic            r_done;
    logic [NR-1:0]   r_shadow;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      w_idx_nxt;
    logic [7:0]      w_idx_inc;
    logic            w_rd_seq_nxt;
    logic            w_busy_rd_nxt;
    logic            w_busy_wr_nxt;
    logic            w_pgmen_nxt;
    logic            w_rden_nxt;
    logic            w_aen_nxt;
    logic [7:0]      w_addr_nxt;
    logic            w_accept_wr;
    logic            w_capture;
    logic            w_enables;
    logic [255:0]    w_wr_pad;

    // Zero-padded to 256 bits so an 8-bit index always selects in range.
    assign w_wr_pad  = 256'(r_wr);
    assign w_idx_inc = r_idx + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rd_seq  <= 1'b0;
            r_wr      <= '0;
            r_busy_rd <= 1'b0;
            r_busy_wr <= 1'b0;
            r_pgmen   <= 1'b0;
            r_rden    <= 1'b0;
            r_aen     <= 1'b0;
            r_addr    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_rd_seq  <= w_rd_seq_nxt;
            r_busy_rd <= w_busy_rd_nxt;
            r_busy_wr <= w_busy_wr_nxt;
            r_pgmen   <= w_pgmen_nxt;
            r_rden    <= w_rden_nxt;
            r_aen     <= w_aen_nxt;
            r_addr    <= w_addr_nxt;
            r_done    <= (w_state_nxt == S_DONE);
            if (w_accept_wr) begin
                r_wr <= wr_data;
            end
        end
    end

    // Shadow capture happens on the last HOLD cycle, one cycle after the
    // mux's registered strobe has produced valid data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_capture) begin
            for (int b = 0; b < NB; b++) begin
                if (r_idx == 8'(b)) begin
                    r_shadow[8*b +: 8] <= read_rdata;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_rd_seq_nxt  = r_rd_seq;
        w_busy_rd_nxt = r_busy_rd;
        w_busy_wr_nxt = r_busy_wr;
        w_accept_wr   = 1'b0;
        w_capture     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_read) begin
                    w_state_nxt   = S_SETUP;
                    w_cnt_nxt     = C_SU;
                    w_idx_nxt     = '0;
                    w_rd_seq_nxt  = 1'b1;
                    w_busy_rd_nxt = 1'b1;
                end else if (start_write) begin
                    w_accept_wr   = 1'b1;
                    w_idx_nxt     = '0;
                    w_rd_seq_nxt  = 1'b0;
                    w_busy_wr_nxt = 1'b1;
                    // Clear bits cost a single NEXT cycle and no strobe.
                    if (wr_data[0]) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = C_SU;
                    end else begin
                        w_state_nxt = S_NEXT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = r_rd_seq ? C_RD : C_PGM;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                    w_capture   = r_rd_seq;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_NEXT: begin
                w_cnt_nxt = '0;
                if (r_rd_seq) begin
                    if (r_idx == LAST_RD) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = C_SU;
                    end
                end else if (r_idx == LAST_WR) begin
`ifdef EFUSE_SEQ_VERIFY_EN
                    // Read-back pass; busy_write stays high through it.
                    w_idx_nxt    = '0;
                    w_rd_seq_nxt = 1'b1;
                    w_state_nxt  = S_SETUP;
                    w_cnt_nxt    = C_SU;
`else
                    w_state_nxt  = S_DONE;
`endif
                end else begin
                    w_idx_nxt = w_idx_inc;
                    if (w_wr_pad[w_idx_inc]) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = C_SU;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt   = S_IDLE;
                w_cnt_nxt     = '0;
                w_busy_rd_nxt = 1'b0;
                w_busy_wr_nxt = 1'b0;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_cnt_nxt     = '0;
                w_busy_rd_nxt = 1'b0;
                w_busy_wr_nxt = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop that
    // lines up with the state register.
    always_comb begin
        w_enables   = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                      (w_state_nxt == S_HOLD);
        w_rden_nxt  = w_enables && w_rd_seq_nxt;
        w_pgmen_nxt = w_enables && !w_rd_seq_nxt;
        w_aen_nxt   = (w_state_nxt == S_STROBE);
        w_addr_nxt  = ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE)) ? 8'd0 : w_idx_nxt;
    end

`ifdef EFUSE_SEQ_VERIFY_EN
    localparam logic [8:0] NWB_FULL = 9'(NW / 8);

    logic       r_err;
    logic [7:0] w_wr_byte;

    assign w_wr_byte = w_wr_pad[{r_idx[4:0], 3'b000} +: 8];

    // Only the verify pass of a program operation checks bytes, and only
    // bytes fully covered by wr_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept_wr) begin
            r_err <= 1'b0;
        end else if (w_capture && r_busy_wr && ({1'b0, r_idx} < NWB_FULL) &&
                     ((w_wr_byte & ~read_rdata) != 8'd0)) begin
            r_err <= 1'b1;
        end
    end

    assign pgm_err = r_err;
`else
    assign pgm_err = 1'b0;
`endif

    assign done        = r_done;
    assign shadow_data = r_shadow;
    assign busy_read   = r_busy_rd;
    assign busy_write  = r_busy_wr;
    assign efuse_pgmen = r_pgmen;
    assign efuse_rden  = r_rden;
    assign efuse_aen   = r_aen;
    assign efuse_addr  = r_addr;

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// tb/tb_efuse_seq_ctrl.sv - directed self-checking bench for efuse_seq_ctrl

module tb_efuse_seq_ctrl;

    localparam int NW = 64;
    localparam int NR = 64;

`ifdef EFUSE_SEQ_VERIFY_EN
    localparam int LAT_W8001 = 345;
    localparam int LAT_W0    = 137;
    localparam int AEN_W8001 = 232;
    localparam int AEN_W0    = 32;
`else
    localparam int LAT_W8001 = 273;
    localparam int LAT_W0    = 65;
    localparam int AEN_W8001 = 200;
    localparam int AEN_W0    = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_read = 1'b0;
    logic          start_write = 1'b0;
    logic [NW-1:0] wr_data = '0;
    logic          done;
    logic [NR-1:0] shadow_data;
    logic          pgm_err;
    logic          busy_read;
    logic          busy_write;
    logic          efuse_pgmen;
    logic          efuse_rden;
    logic          efuse_aen;
    logic [7:0]    efuse_addr;
    logic [7:0]    read_rdata;

    int errors = 0;
    int checks = 0;

    int            fuse_mode = 0;
    logic          fuse_clr = 1'b0;
    logic [2047:0] fuse_bits;

    int         n_aen, n_both, n_bad, n_pgmen, n_brd, n_bwr;
    logic [7:0] strobe_addr [$];
    logic       prev_aen;
    int         lat;

    always #5 clk = ~clk;

    efuse_seq_ctrl #(.NW(NW), .NR(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_read  (start_read),
        .start_write (start_write),
        .wr_data     (wr_data),
        .done        (done),
        .shadow_data (shadow_data),
        .pgm_err     (pgm_err),
        .busy_read   (busy_read),
        .busy_write  (busy_write),
        .efuse_pgmen (efuse_pgmen),
        .efuse_rden  (efuse_rden),
        .efuse_aen   (efuse_aen),
        .efuse_addr  (efuse_addr),
        .read_rdata  (read_rdata)
    );

    // Fuse model: 0 = 8'hA0+byte index, 1 = all zeros, 2 = bits burned so far.
    always @(posedge clk) begin
        if (fuse_clr)
            fuse_bits <= '0;
        else if (efuse_aen && efuse_pgmen)
            fuse_bits[efuse_addr] <= 1'b1;
    end

    always_comb begin
        case (fuse_mode)
            1:       read_rdata = 8'h00;
            2:       read_rdata = fuse_bits[{efuse_addr, 3'b000} +: 8];
            default: read_rdata = 8'hA0 + efuse_addr;
        endcase
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller raises start_* before calling; the acceptance edge is taken here
    // and the cycle after it is cycle 1. Returns the done cycle, or -1.
    task automatic run_op(input int limit, input int inject_at, output int cyc);
        int n;
        n_aen = 0; n_both = 0; n_bad = 0; n_pgmen = 0; n_brd = 0; n_bwr = 0;
        strobe_addr.delete();
        prev_aen = 1'b0;
        step();
        start_read  = 1'b0;
        start_write = 1'b0;
        n   = 1;
        cyc = -1;
        while (n <= limit) begin
            if (efuse_aen) n_aen++;
            if (efuse_aen && !prev_aen) strobe_addr.push_back(efuse_addr);
            if (efuse_pgmen && efuse_rden) n_both++;
            if (efuse_aen && !(efuse_pgmen ^ efuse_rden)) n_bad++;
            if (efuse_pgmen) n_pgmen++;
            if (busy_read) n_brd++;
            if (busy_write) n_bwr++;
            prev_aen = efuse_aen;
            if (done) begin
                cyc = n;
                break;
            end
            if (n == inject_at) start_write = 1'b1;
            step();
            start_write = 1'b0;
            n++;
        end
        if (cyc < 0) check("op_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        fuse_clr = 1'b1;
        step();
        step();
        fuse_clr = 1'b0;

        // Reset state
        check("rst_outputs", {done, pgm_err, busy_read, busy_write, efuse_pgmen,
                              efuse_rden, efuse_aen, efuse_addr}, '0);
        check("rst_shadow", shadow_data, '0);

        // Reset in the middle of a read
        rst_n = 1'b1;
        step();
        start_read = 1'b1;
        step();
        start_read = 1'b0;
        repeat (9) step();
        check("midread_rden_addr", {efuse_rden, efuse_addr, busy_read}, {1'b1, 8'd1, 1'b1});
        rst_n = 1'b0;
        step();
        check("midread_rst_outputs", {done, busy_read, busy_write, efuse_pgmen,
                                      efuse_rden, efuse_aen, efuse_addr}, '0);
        check("midread_rst_shadow", shadow_data, '0);
        rst_n = 1'b1;
        step();
        step();
        check("midread_idle", {busy_read, busy_write, done}, 3'b000);

        // Full read with the A0+k fuse model
        fuse_mode  = 0;
        start_read = 1'b1;
        run_op(500, -1, lat);
        check("read_latency", lat, 73);
        check("read_busy_read_cycles", n_brd, 73);
        check("read_busy_write_cycles", n_bwr, 0);
        check("read_aen_cycles", n_aen, 32);
        check("read_pgmen_cycles", n_pgmen, 0);
        check("read_shadow", shadow_data, 64'hA7A6A5A4A3A2A1A0);
        // a start during DONE must be ignored
        start_write = 1'b1;
        step();
        start_write = 1'b0;
        check("after_done_idle", {done, busy_read, busy_write, efuse_addr}, '0);
        step();

        // Program 0x8001
        fuse_mode   = 2;
        wr_data     = 64'h0000_0000_0000_8001;
        start_write = 1'b1;
        run_op(2000, -1, lat);
        check("pgm_latency", lat, LAT_W8001);
        check("pgm_busy_write_cycles", n_bwr, LAT_W8001);
        check("pgm_busy_read_cycles", n_brd, 0);
        check("pgm_aen_cycles", n_aen, AEN_W8001);
        check("pgm_pgmen_cycles", n_pgmen, 2 * 104);
        check("pgm_strobe0_addr", strobe_addr.size() > 0 ? strobe_addr[0] : 8'hFF, 8'd0);
        check("pgm_strobe1_addr", strobe_addr.size() > 1 ? strobe_addr[1] : 8'hFF, 8'd15);
        check("pgm_no_overlap", n_both, 0);
        check("pgm_aen_exclusive", n_bad, 0);
        check("pgm_shadow_kept", shadow_data,
`ifdef EFUSE_SEQ_VERIFY_EN
              64'h0000_0000_0000_8001);
`else
              64'hA7A6A5A4A3A2A1A0);
`endif
        check("pgm_err_clean", pgm_err, 1'b0);
        step();

        // Simultaneous start: read wins
        fuse_mode   = 0;
        wr_data     = 64'hFFFF_FFFF_FFFF_FFFF;
        start_read  = 1'b1;
        start_write = 1'b1;
        run_op(500, -1, lat);
        check("both_latency", lat, 73);
        check("both_busy_write_cycles", n_bwr, 0);
        check("both_pgmen_cycles", n_pgmen, 0);
        step();

        // start_write in the middle of a read is ignored
        start_read = 1'b1;
        run_op(500, 20, lat);
        check("midwr_latency", lat, 73);
        check("midwr_busy_write_cycles", n_bwr, 0);
        check("midwr_pgmen_cycles", n_pgmen, 0);
        step();

        // Program an all-zero word
        fuse_mode   = 2;
        fuse_clr    = 1'b1;
        step();
        fuse_clr    = 1'b0;
        wr_data     = '0;
        start_write = 1'b1;
        run_op(1000, -1, lat);
        check("zero_latency", lat, LAT_W0);
        check("zero_pgmen_cycles", n_pgmen, 0);
        check("zero_aen_cycles", n_aen, AEN_W0);
        check("zero_pgm_err", pgm_err, 1'b0);
        step();

`ifdef EFUSE_SEQ_VERIFY_EN
        // Verify with a fuse that never burns
        fuse_mode   = 1;
        wr_data     = 64'h1;
        start_write = 1'b1;
        run_op(2000, -1, lat);
        check("vfy_fail_latency", lat, 104 + 64 + 72 + 1);
        check("vfy_fail_err", pgm_err, 1'b1);
        check("vfy_fail_busy_read", n_brd, 0);
        step();

        // Verify with a fuse that burns correctly; err clears on accept
        fuse_mode   = 2;
        fuse_clr    = 1'b1;
        step();
        fuse_clr    = 1'b0;
        start_write = 1'b1;
        run_op(2000, -1, lat);
        check("vfy_ok_err", pgm_err, 1'b0);
        check("vfy_ok_shadow", shadow_data, 64'h1);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
